// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: round-robin sequencer for one single-ported line memory
// shared by the instruction-cache fill path and the data-cache fill/writeback
// path. One request is served at a time: Idle -> Access (MemLatency cycles)
// -> Done (one-cycle done pulse) -> Idle.
module line_mem_arbiter #(
    parameter int LineWidth  = 64,
    parameter int AddrWidth  = 29,
    parameter int MemLatency = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AddrWidth-1:0] icAddr,
    input  logic                 icReadReq,
    output logic                 icGrant,
    output logic                 icDone,
    output logic [LineWidth-1:0] icReadValue,
    input  logic [AddrWidth-1:0] dcAddr,
    input  logic                 dcReadReq,
    input  logic                 dcWriteReq,
    input  logic [LineWidth-1:0] dcWriteValue,
    output logic                 dcGrant,
    output logic                 dcDone,
    output logic [LineWidth-1:0] dcReadValue,
    output logic [AddrWidth-1:0] memAddr,
    output logic                 memWriteEnable,
    output logic [LineWidth-1:0] memWriteValue,
    input  logic [LineWidth-1:0] memReadValue,
    output logic                 busy
);

    // Four bits cover the full 1..15 latency range.
    localparam int CntW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  owner_q, owner_d;       // 1 = data side owns the memory
    logic                  write_q, write_d;       // 1 = current access is a write
    logic                  last_dc_q, last_dc_d;   // 1 = data side was served last
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [LineWidth-1:0]  wdata_q, wdata_d;
    logic [LineWidth-1:0]  ic_rdata_q, ic_rdata_d;
    logic [LineWidth-1:0]  dc_rdata_q, dc_rdata_d;

    logic ic_pend;
    logic dc_pend;
    logic sel_dc;

    assign ic_pend = icReadReq;
    assign dc_pend = dcReadReq | dcWriteReq;
    // On a tie the side that was not served last wins.
    assign sel_dc  = dc_pend & (~ic_pend | ~last_dc_q);

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            write_q    <= 1'b0;
            last_dc_q  <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            write_q    <= write_d;
            last_dc_q  <= last_dc_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
        end
    end

    // Next-state logic: arbitration in Idle, latency countdown in Access.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        write_d    = write_q;
        last_dc_d  = last_dc_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        case (state_q)
            IDLE: begin
                if (ic_pend || dc_pend) begin
                    owner_d = sel_dc;
                    cnt_d   = CntW'(MemLatency - 1);
                    state_d = ACCESS;
                    if (sel_dc) begin
                        addr_d  = dcAddr;
                        write_d = dcWriteReq;   // write wins over a concurrent read
                        wdata_d = dcWriteValue;
                    end else begin
                        addr_d  = icAddr;
                        write_d = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!write_q) begin
                        if (owner_q) dc_rdata_d = memReadValue;
                        else         ic_rdata_d = memReadValue;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                last_dc_d = owner_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign icGrant        = busy & ~owner_q;
    assign dcGrant        = busy &  owner_q;
    assign icDone         = (state_q == DONE) & ~owner_q;
    assign dcDone         = (state_q == DONE) &  owner_q;
    assign icReadValue    = ic_rdata_q;
    assign dcReadValue    = dc_rdata_q;
    assign memAddr        = addr_q;
    assign memWriteValue  = wdata_q;
    assign memWriteEnable = (state_q == ACCESS) & (cnt_q == '0) & write_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed testbench for line_mem_arbiter: main instance at MemLatency=2 with
// a small line-memory model, plus MemLatency=1 and 15 instances for latency.
module tb_line_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [28:0] icAddr, dcAddr;
    logic        icReadReq, dcReadReq, dcWriteReq;
    logic [63:0] dcWriteValue;
    logic        icGrant, icDone, dcGrant, dcDone, memWriteEnable, busy;
    logic [63:0] icReadValue, dcReadValue, memWriteValue, memReadValue;
    logic [28:0] memAddr;

    // latency-build instances
    logic        l1_req, l15_req;
    logic [28:0] lat_addr;
    logic        l1_icGrant, l1_icDone, l1_dcGrant, l1_dcDone, l1_we, l1_busy;
    logic [63:0] l1_icRV, l1_dcRV, l1_wv;
    logic [28:0] l1_maddr;
    logic        l15_icGrant, l15_icDone, l15_dcGrant, l15_dcDone, l15_we, l15_busy;
    logic [63:0] l15_icRV, l15_dcRV, l15_wv;
    logic [28:0] l15_maddr;

    logic [63:0] mem [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign memReadValue = mem[memAddr[3:0]];

    // memory model: write on the rising edge while the strobe is high
    always @(posedge clk) begin
        if (memWriteEnable) mem[memAddr[3:0]] <= memWriteValue;
    end

    line_mem_arbiter #(.LineWidth(64), .AddrWidth(29), .MemLatency(2)) dut (
        .clk(clk), .rst(rst),
        .icAddr(icAddr), .icReadReq(icReadReq), .icGrant(icGrant), .icDone(icDone),
        .icReadValue(icReadValue),
        .dcAddr(dcAddr), .dcReadReq(dcReadReq), .dcWriteReq(dcWriteReq),
        .dcWriteValue(dcWriteValue), .dcGrant(dcGrant), .dcDone(dcDone),
        .dcReadValue(dcReadValue),
        .memAddr(memAddr), .memWriteEnable(memWriteEnable), .memWriteValue(memWriteValue),
        .memReadValue(memReadValue), .busy(busy)
    );

    line_mem_arbiter #(.LineWidth(64), .AddrWidth(29), .MemLatency(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .icAddr(lat_addr), .icReadReq(l1_req), .icGrant(l1_icGrant), .icDone(l1_icDone),
        .icReadValue(l1_icRV),
        .dcAddr(29'd0), .dcReadReq(1'b0), .dcWriteReq(1'b0),
        .dcWriteValue(64'd0), .dcGrant(l1_dcGrant), .dcDone(l1_dcDone),
        .dcReadValue(l1_dcRV),
        .memAddr(l1_maddr), .memWriteEnable(l1_we), .memWriteValue(l1_wv),
        .memReadValue({35'd0, l1_maddr}), .busy(l1_busy)
    );

    line_mem_arbiter #(.LineWidth(64), .AddrWidth(29), .MemLatency(15)) dut_l15 (
        .clk(clk), .rst(rst),
        .icAddr(lat_addr), .icReadReq(l15_req), .icGrant(l15_icGrant), .icDone(l15_icDone),
        .icReadValue(l15_icRV),
        .dcAddr(29'd0), .dcReadReq(1'b0), .dcWriteReq(1'b0),
        .dcWriteValue(64'd0), .dcGrant(l15_dcGrant), .dcDone(l15_dcDone),
        .dcReadValue(l15_dcRV),
        .memAddr(l15_maddr), .memWriteEnable(l15_we), .memWriteValue(l15_wv),
        .memReadValue({35'd0, l15_maddr}), .busy(l15_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 64'h0;
        mem[5] = 64'h0b0b0b0b0a0a0a0a;
        mem[7] = 64'h7777000012345678;
        rst = 1'b0;
        icAddr = '0; dcAddr = '0; icReadReq = 0; dcReadReq = 0; dcWriteReq = 0;
        dcWriteValue = '0; l1_req = 0; l15_req = 0; lat_addr = '0;

        // ---- reset state
        nc(); nc();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grants", 64'({icGrant, dcGrant}), 64'd0);
        chk("rst_dones", 64'({icDone, dcDone, memWriteEnable}), 64'd0);
        chk("rst_memaddr", 64'(memAddr), 64'd0);
        chk("rst_wval", memWriteValue, 64'd0);
        chk("rst_icrv", icReadValue, 64'd0);
        chk("rst_dcrv", dcReadValue, 64'd0);
        rst = 1'b1;

        // ---- single fetch read of line 5
        nc();                                   // cycle 0
        icAddr = 29'd5; icReadReq = 1;
        chk("t1_c0_icgrant", 64'(icGrant), 64'd0);
        for (int c = 1; c <= 3; c++) begin
            nc();
            chk("t1_icgrant", 64'(icGrant), 64'd1);
            chk("t1_dcgrant", 64'(dcGrant), 64'd0);
            chk("t1_icdone", 64'(icDone), 64'(c == 3));
            chk("t1_memaddr", 64'(memAddr), 64'd5);
        end
        chk("t1_icrv", icReadValue, 64'h0b0b0b0b0a0a0a0a);
        icReadReq = 0;
        $display("txn fetch read addr=5 line=%h", icReadValue);
        nc();
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // ---- data write line 3
        dcAddr = 29'd3; dcWriteValue = 64'hdeadbeefcafef00d; dcWriteReq = 1;   // cycle 0
        nc();                                   // cycle 1
        chk("t2_c1_we", 64'(memWriteEnable), 64'd0);
        chk("t2_c1_dcgrant", 64'(dcGrant), 64'd1);
        nc();                                   // cycle 2
        chk("t2_c2_we", 64'(memWriteEnable), 64'd1);
        chk("t2_c2_memaddr", 64'(memAddr), 64'd3);
        chk("t2_c2_wval", memWriteValue, 64'hdeadbeefcafef00d);
        chk("t2_c2_dcdone", 64'(dcDone), 64'd0);
        nc();                                   // cycle 3
        chk("t2_c3_we", 64'(memWriteEnable), 64'd0);
        chk("t2_c3_dcdone", 64'(dcDone), 64'd1);
        chk("t2_dcrv_untouched", dcReadValue, 64'd0);
        dcWriteReq = 0;
        $display("txn data write addr=3 data=deadbeefcafef00d");
        nc();
        // data read back line 3
        dcReadReq = 1;                          // cycle 0
        nc(); nc(); nc();                       // cycle 3
        chk("t2r_dcdone", 64'(dcDone), 64'd1);
        chk("t2r_dcrv", dcReadValue, 64'hdeadbeefcafef00d);
        dcReadReq = 0;
        $display("txn data read addr=3 line=%h", dcReadValue);
        nc();

        // ---- simultaneous reads from reset: strict alternation
        rst = 1'b0;
        nc();
        rst = 1'b1;
        icAddr = 29'd5; dcAddr = 29'd7; icReadReq = 1; dcReadReq = 1;   // cycle 0
        for (int c = 1; c <= 11; c++) begin
            nc();
            chk("t3_icdone", 64'(icDone), 64'(c == 3 || c == 11));
            chk("t3_dcdone", 64'(dcDone), 64'(c == 7));
            if (c == 7) chk("t3_dcrv", dcReadValue, 64'h7777000012345678);
            if (c == 11) chk("t3_icrv", icReadValue, 64'h0b0b0b0b0a0a0a0a);
        end
        icReadReq = 0; dcReadReq = 0;
        $display("txn alternation fetch@3 data@7 fetch@11");
        nc();

        // ---- read+write together is a write
        dcAddr = 29'd9; dcWriteValue = 64'h1122334455667788;
        dcReadReq = 1; dcWriteReq = 1;          // cycle 0
        nc(); nc();                             // cycle 2
        chk("t4_we", 64'(memWriteEnable), 64'd1);
        chk("t4_wval", memWriteValue, 64'h1122334455667788);
        nc();                                   // cycle 3
        chk("t4_dcdone", 64'(dcDone), 64'd1);
        chk("t4_dcrv_kept", dcReadValue, 64'h7777000012345678);
        dcReadReq = 0; dcWriteReq = 0;
        $display("txn data read+write addr=9 treated as write");
        nc();

        // ---- reset during a write access
        dcAddr = 29'd11; dcWriteValue = 64'habcdef0123456789; dcWriteReq = 1;  // cycle 0
        nc();                                   // cycle 1, first Access cycle
        chk("t5_pre_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("t5_async_busy", 64'(busy), 64'd0);
        chk("t5_async_grant", 64'(dcGrant), 64'd0);
        chk("t5_async_memaddr", 64'(memAddr), 64'd0);
        chk("t5_async_wval", memWriteValue, 64'd0);
        chk("t5_async_dcrv", dcReadValue, 64'd0);
        for (int c = 2; c <= 3; c++) begin
            nc();
            chk("t5_rst_we", 64'(memWriteEnable), 64'd0);
            chk("t5_rst_done", 64'({icDone, dcDone}), 64'd0);
        end
        chk("t5_mem11_unwritten", mem[11], 64'd0);
        rst = 1'b1;                             // new cycle 0, request still held
        nc(); nc();                             // cycle 2
        chk("t5r_we", 64'(memWriteEnable), 64'd1);
        chk("t5r_memaddr", 64'(memAddr), 64'd11);
        nc();                                   // cycle 3
        chk("t5r_dcdone", 64'(dcDone), 64'd1);
        dcWriteReq = 0;
        $display("txn reset-abandoned write addr=11 then restarted");
        nc();

        // ---- latency builds 1 and 15
        lat_addr = 29'h1234; l1_req = 1; l15_req = 1;   // cycle 0
        for (int c = 1; c <= 16; c++) begin
            nc();
            chk("t6_l1_done", 64'(l1_icDone), 64'(c == 2));
            chk("t6_l15_done", 64'(l15_icDone), 64'(c == 16));
            if (c == 2) begin
                chk("t6_l1_rv", l1_icRV, 64'h1234);
                l1_req = 0;
            end
            if (c == 16) begin
                chk("t6_l15_rv", l15_icRV, 64'h1234);
                l15_req = 0;
            end
        end
        $display("txn latency builds: L=1 done@2, L=15 done@16");
        nc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

Sequences one single-ported line memory between the instruction-cache fill path and the data-cache fill/writeback path. Accepts line-granular read requests from the fetch side and read or write requests from the data side, grants one at a time with round-robin fairness, holds the memory address for a fixed access latency, and returns the line with a one-cycle done pulse. Sits between the fetch unit / data cache and the line memory model or memory controller.

## Interface
- LineWidth, 64: line width in bits (8-byte cache line).
- AddrWidth, 29: line address width (32-bit address minus 3 offset bits).
- MemLatency, 2: cycles the address is held before read data is sampled; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- icAddr  in  AddrWidth  fetch-side line address.
- icReadReq  in  1  fetch-side read request, level.
- icGrant  out  1  high while the fetch request is being served.
- icDone  out  1  one-cycle pulse; icReadValue valid this cycle.
- icReadValue  out  LineWidth  returned line.
- dcAddr  in  AddrWidth  data-side line address.
- dcReadReq  in  1  data-side read request, level.
- dcWriteReq  in  1  data-side write request, level.
- dcWriteValue  in  LineWidth  line to write.
- dcGrant  out  1  high while a data-side request is being served.
- dcDone  out  1  one-cycle pulse; completes read or write.
- dcReadValue  out  LineWidth  returned line (data reads only).
- memAddr  out  AddrWidth  memory line address.
- memWriteEnable  out  1  memory write strobe.
- memWriteValue  out  LineWidth  memory write data.
- memReadValue  in  LineWidth  memory read data, combinational from memAddr.
- busy  out  1  high in any state but Idle.

## Operation
- States: Idle, Access, Done.
- Idle: evaluate requests. Fetch pending = icReadReq; data pending = dcReadReq | dcWriteReq. One pending → select it. Both pending → select the requester not served last (lastServed register). Selection latches owner, address, kind (read/write), write data; load counter = MemLatency-1; go to Access. Nothing pending → stay.
- Data side kind: dcWriteReq=1 → write (dcReadReq ignored); else read.
- Access: memAddr = latched address; owner's grant high. Counter decrements each cycle. On the cycle counter = 0: read → capture memReadValue into owner's readValue register; write → memWriteEnable=1 for exactly this cycle with memWriteValue = latched data. Then go to Done.
- Done: owner's done pulses for one cycle, grant still high; readValue holds captured line (retained until next capture for that owner). Update lastServed = owner. Go to Idle unconditionally.
- Requesters hold req, addr and write data stable from assertion until done; served requester deasserts req by the edge following done. Address/data changes mid-request are ignored (latched in Idle).
- memAddr, memWriteValue hold latched values outside Access; memWriteEnable low outside the final Access cycle.
- Reset (rst=0, any time): state Idle, lastServed = data side (fetch wins first tie), counter 0, all grants/dones/memWriteEnable/busy 0, memAddr 0, memWriteValue 0, readValue registers 0. Access in progress is abandoned: no done, no write strobe, effective immediately (asynchronous).

## Timing
- Request seen in Idle at cycle t: Access cycles t+1 .. t+MemLatency, write strobe / read capture at t+MemLatency, done at t+MemLatency+1, Idle at t+MemLatency+2.
- Default MemLatency=2: request-to-done 3 cycles; back-to-back service interval MemLatency+2 = 4 cycles.
- Both requesters continuously pending: strict alternation, each served once per 2·(MemLatency+2) cycles; no starvation.
- Request arriving during Access/Done waits until next Idle; no bypass.
- grant is a registered state decode; done asserted only in Done state; at most one of icDone/dcDone high in any cycle.

## Test plan
- Single fetch read, MemLatency=2, memory line 5 = 64'h0b0b0b0b0a0a0a0a: icReadReq with icAddr=5 at cycle 0 -> icGrant cycles 1-3, icDone cycle 3 with icReadValue=64'h0b0b0b0b0a0a0a0a, dcGrant never high.
- Data write then read: dcWriteReq, dcAddr=3, dcWriteValue=64'hdeadbeefcafef00d -> memWriteEnable exactly one cycle (cycle 2) at memAddr=3, dcDone cycle 3; then dcReadReq addr 3 -> dcReadValue=64'hdeadbeefcafef00d.
- Simultaneous ic and dc reads from reset, both held -> fetch served first (icDone cycle 3), data next (dcDone cycle 7), then fetch again (cycle 11).
- dcReadReq and dcWriteReq both high -> treated as write; dcReadValue unchanged.
- rst driven low in middle Access cycle of a write -> memWriteEnable never asserted, no done, all outputs 0 immediately; after release a held request restarts from Idle and completes normally.
- MemLatency=1 and MemLatency=15 builds: request-to-done 2 and 16 cycles respectively.
